// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared pipeline definitions for the fetch stage: the fetch FSM state
// encoding, the default reset fetch address and the instruction width.
// No ports; imported by fetch_stage and if_id_reg.
package fetch_stage_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // BOOT spends one idle cycle after reset so the first fetch starts from a
    // clean pipeline; HALTED is sticky until the next reset.
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg
// IF/ID pipeline register holding {instruction, pc, pc+4} plus a valid bit.
// Ports:
//   clk    - clock, all updates on posedge
//   reset  - synchronous active-low reset, clears data and valid
//   stall  - hold the current contents
//   flush  - write a bubble (valid=0); wins over stall
//   din    - packed {instr, pc, pc4} to capture on a normal load
//   dout   - registered packed {instr, pc, pc4}
//   valid  - dout holds a real instruction
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int W = INSTR_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           flush,
    input  logic [3*W-1:0] din,
    output logic [3*W-1:0] dout,
    output logic           valid
);

    // A flush only kills the valid bit; the data fields are left alone since
    // they are don't-care while valid is low and were zeroed at reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!stall) begin
            dout  <= din;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: PC register, BOOT/RUN/HALTED control FSM, fetch counter
// and the IF/ID pipeline register.
// Ports:
//   clk, reset      - clock; synchronous active-low reset
//   stall, flush    - hold PC and IF/ID / insert a bubble into IF/ID
//   redirect_valid  - load redirect_pc (word aligned) into PC this cycle
//   redirect_pc     - branch/jump target
//   halt_req        - stop fetching until reset
//   imem_addr       - instruction memory address (always the PC)
//   imem_rdata      - combinational instruction word for imem_addr
//   if_id_instr/pc/pc4/valid - IF/ID register contents for decode
//   halted          - FSM is in HALTED
//   fetch_count     - number of instructions written valid into IF/ID
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          W        = INSTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         redirect_valid,
    input  logic [W-1:0] redirect_pc,
    input  logic         halt_req,
    output logic [W-1:0] imem_addr,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] if_id_instr,
    output logic [W-1:0] if_id_pc,
    output logic [W-1:0] if_id_pc4,
    output logic         if_id_valid,
    output logic         halted,
    output logic [31:0]  fetch_count
);

    localparam logic [W-1:0] ALIGN_MASK = {{(W-2){1'b1}}, 2'b00};

    fetch_state_t   state, next_state;
    logic [W-1:0]   pc, pc_next, pc_plus4;
    logic           fetch;
    logic           ifid_stall;
    logic           ifid_flush;
    logic [3*W-1:0] ifid_din;
    logic [3*W-1:0] ifid_dout;

    // Plain W-bit addition, so the last word wraps back to address 0.
    assign pc_plus4  = pc + W'(4);
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    // State, PC and fetch counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= W'(RESET_PC);
            fetch_count <= '0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
            if (fetch) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    // Next-state and PC/IF-ID control. Defaults describe "do nothing": PC
    // holds and IF/ID gets a bubble; only the plain fetch path loads IF/ID.
    // Priority in RUN is redirect, then halt, then flush/stall, then fetch.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        fetch      = 1'b0;
        ifid_stall = 1'b1;
        ifid_flush = 1'b1;
        case (state)
            BOOT: begin
                next_state = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc & ALIGN_MASK;
                end else if (halt_req) begin
                    next_state = HALTED;
                end else if (flush) begin
                    if (!stall) begin
                        pc_next = pc_plus4;
                    end
                end else if (stall) begin
                    ifid_flush = 1'b0;
                end else begin
                    ifid_flush = 1'b0;
                    ifid_stall = 1'b0;
                    fetch      = 1'b1;
                    pc_next    = pc_plus4;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    assign ifid_din = {imem_rdata, pc, pc_plus4};

    if_id_reg #(
        .W (W)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .stall (ifid_stall),
        .flush (ifid_flush),
        .din   (ifid_din),
        .dout  (ifid_dout),
        .valid (if_id_valid)
    );

    assign {if_id_instr, if_id_pc, if_id_pc4} = ifid_dout;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed self-checking bench for fetch_stage. A small combinational
// instruction memory answers every address; expected values are written
// out by hand for each step.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int compareCount  = 0;
    int mismatchCount = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .W        (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program words at 0 and 4; every other address returns a tag built
    // from its low half so a wrong fetch address shows up in the data.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0)      return 32'h2008_0005;
        else if (addr == 32'h4) return 32'h2009_0003;
        else                    return {addr[15:0], 16'hC0DE};
    endfunction

    always_comb imem_rdata = memWord(imem_addr);

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock once and settle 1ns past the edge.
    task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                                 input logic rv, input logic [31:0] rpc,
                                 input logic hr);
        reset          = rst;
        stall          = stl;
        flush          = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        #1;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
        checkOutput("rst_addr",  imem_addr, 32'h0);
        checkOutput("rst_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("rst_halt",  {31'b0, halted}, 32'h0);
        checkOutput("rst_count", fetch_count, 32'h0);
        checkOutput("rst_pc",    if_id_pc, 32'h0);
        checkOutput("rst_instr", if_id_instr, 32'h0);
        checkOutput("rst_pc4",   if_id_pc4, 32'h0);

        // BOOT cycle: no fetch
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("boot_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("boot_addr",  imem_addr, 32'h0);
        checkOutput("boot_count", fetch_count, 32'h0);

        // First two fetches
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("f0_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("f0_pc",    if_id_pc, 32'h0);
        checkOutput("f0_instr", if_id_instr, 32'h2008_0005);
        checkOutput("f0_count", fetch_count, 32'd1);
        checkOutput("f0_addr",  imem_addr, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("f1_pc",    if_id_pc, 32'h4);
        checkOutput("f1_pc4",   if_id_pc4, 32'h8);
        checkOutput("f1_instr", if_id_instr, 32'h2009_0003);
        checkOutput("f1_count", fetch_count, 32'd2);

        // Flush at PC=0x8, then flush together with stall
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("fl_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("fl_addr",  imem_addr, 32'hC);
        checkOutput("fl_count", fetch_count, 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("flst_addr",  imem_addr, 32'hC);
        checkOutput("flst_valid", {31'b0, if_id_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("fC_pc",    if_id_pc, 32'hC);
        checkOutput("fC_instr", if_id_instr, 32'h000C_C0DE);
        checkOutput("fC_count", fetch_count, 32'd3);

        // Stall three cycles at PC=0x10
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("st_addr",  imem_addr, 32'h10);
            checkOutput("st_pc",    if_id_pc, 32'hC);
            checkOutput("st_instr", if_id_instr, 32'h000C_C0DE);
            checkOutput("st_valid", {31'b0, if_id_valid}, 32'h1);
            checkOutput("st_count", fetch_count, 32'd3);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("str_pc",    if_id_pc, 32'h10);
        checkOutput("str_count", fetch_count, 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("str2_pc",    if_id_pc, 32'h14);
        checkOutput("str2_count", fetch_count, 32'd5);

        // Redirect while stalled, unaligned target
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0043, 1'b0);
        checkOutput("rd_addr",  imem_addr, 32'h40);
        checkOutput("rd_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("rd_count", fetch_count, 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rd_pc",    if_id_pc, 32'h40);
        checkOutput("rd_instr", if_id_instr, 32'h0040_C0DE);
        checkOutput("rd_count2", fetch_count, 32'd6);

        // Wrap at the top of the address space
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        checkOutput("wr_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wr_pc",   if_id_pc, 32'hFFFF_FFFC);
        checkOutput("wr_pc4",  if_id_pc4, 32'h0);
        checkOutput("wr_addr2", imem_addr, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wr_pc2",   if_id_pc, 32'h0);
        checkOutput("wr_count", fetch_count, 32'd8);

        // Halt at PC=0x20
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("h_halted", {31'b0, halted}, 32'h1);
        checkOutput("h_addr",   imem_addr, 32'h20);
        checkOutput("h_valid",  {31'b0, if_id_valid}, 32'h0);
        checkOutput("h_count",  fetch_count, 32'd8);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
            checkOutput("hr_halted", {31'b0, halted}, 32'h1);
            checkOutput("hr_addr",   imem_addr, 32'h20);
            checkOutput("hr_valid",  {31'b0, if_id_valid}, 32'h0);
            checkOutput("hr_count",  fetch_count, 32'd8);
        end

        // One-cycle reset out of HALTED
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        checkOutput("rh_halted", {31'b0, halted}, 32'h0);
        checkOutput("rh_addr",   imem_addr, 32'h0);
        checkOutput("rh_count",  fetch_count, 32'h0);
        checkOutput("rh_valid",  {31'b0, if_id_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rh_boot_valid", {31'b0, if_id_valid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rh_f_valid", {31'b0, if_id_valid}, 32'h1);
        checkOutput("rh_f_instr", if_id_instr, 32'h2008_0005);
        checkOutput("rh_f_count", fetch_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
